// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Sixteen-pin output stage driven by the SPI register block. Each pin is either
// forced low, held high, or follows one shared PWM waveform. The waveform is
// built from a clock prescaler feeding an 8-bit period counter. It is compared
// against a double-buffered duty value, so a duty change only takes effect at
// a period boundary.
//
// Parameters
//   PRESCALE        clk cycles per PWM counter tick (>= 1)
//
// Ports
//   clk             system clock, rising-edge
//   rst             asynchronous active-high reset
//   en_reg_out_7_0  output enable, pins 7:0   (0 = pin forced low)
//   en_reg_out_15_8 output enable, pins 15:8
//   en_reg_pwm_7_0  PWM mode, pins 7:0        (0 = static high, 1 = PWM)
//   en_reg_pwm_15_8 PWM mode, pins 15:8
//   pwm_duty_cycle  requested duty, 0x00 = 0 %, 0xFF = 100 %
//   out             registered pin drive
//   period_start    registered one-clock pulse as the counter wraps to 0
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // Prescaler width: a PRESCALE of 1 still needs one bit so the counter
    // declaration stays legal; the counter then just sits at 0.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

    logic [PRE_W-1:0] pre_cnt_r;
    logic [7:0]       pwm_cnt_r;
    logic [7:0]       duty_shadow_r;

    logic             tick_s;
    logic             wrap_s;
    logic             pwm_level_s;
    logic [15:0]      en_out_s;
    logic [15:0]      en_pwm_s;
    logic [15:0]      out_next_s;

    assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // One tick per PRESCALE clocks; the wrap clock is the tick that moves
    // the period counter from 255 back to 0.
    assign tick_s = (pre_cnt_r == PRE_LAST);
    assign wrap_s = tick_s && (pwm_cnt_r == 8'hFF);

    // Prescaler counter: counts 0..PRESCALE-1 and restarts on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r <= PRE_ZERO;
        end else if (tick_s) begin
            pre_cnt_r <= PRE_ZERO;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
    end

    // Period counter: advances once per tick and wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= 8'h00;
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + 8'h01;
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Duty shadow: captures the requested duty only on the wrap clock, so a
    // period always runs start to finish with a single duty value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow_r <= 8'h00;
        end else if (wrap_s) begin
            duty_shadow_r <= pwm_duty_cycle;
        end else begin
            duty_shadow_r <= duty_shadow_r;
        end
    end

    // Shared PWM level. 0xFF is special-cased to full-on; a plain compare
    // would leave a one-tick low gap at count 255.
    always_comb begin
        pwm_level_s = 1'b0;
        if (duty_shadow_r == 8'hFF) begin
            pwm_level_s = 1'b1;
        end else begin
            pwm_level_s = (pwm_cnt_r < duty_shadow_r);
        end
    end

    // Per-pin select: the enable dominates, then the mode picks static high
    // or the shared PWM level.
    always_comb begin
        out_next_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!en_out_s[i]) begin
                out_next_s[i] = 1'b0;
            end else if (!en_pwm_s[i]) begin
                out_next_s[i] = 1'b1;
            end else begin
                out_next_s[i] = pwm_level_s;
            end
        end
    end

    // Output registers: pins and the period marker are both launched from
    // flops, so the pins never glitch on internal compare transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            out          <= out_next_s;
            period_start <= wrap_s;
        end
    end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Eight-bit PWM generator that sits directly downstream of the SPI register peripheral and consumes its five configuration registers: two output-enable bytes, two PWM-mode bytes and one duty-cycle byte. It drives 16 output pins. Each pin is forced low, held high, or driven by a shared PWM waveform. The duty cycle is double-buffered so that a new value only takes effect at a period boundary, which keeps the waveform glitch-free.

## Interface
- PRESCALE, default 13: `clk` cycles per PWM counter tick, legal range ≥1. With a 10 MHz `clk`, period = 256 × 13 = 3328 clocks (≈3.0 kHz).
- clk  in  1  system clock; every register is on the rising edge.
- rst  in  1  asynchronous, active-high reset; one clock domain only.
- en_reg_out_7_0  in  8  output enable, bits 7:0 (SPI reg 0x00).
- en_reg_out_15_8  in  8  output enable, bits 15:8 (SPI reg 0x01).
- en_reg_pwm_7_0  in  8  PWM mode select, bits 7:0 (SPI reg 0x02).
- en_reg_pwm_15_8  in  8  PWM mode select, bits 15:8 (SPI reg 0x03).
- pwm_duty_cycle  in  8  requested duty (SPI reg 0x04); 0x00 = 0 %, 0xFF = 100 %.
- out  out  16  registered output pins.
- period_start  out  1  registered one-clock pulse at the start of each PWM period.

## Operation
- Internal state:
  - pre_cnt: width clog2(PRESCALE), minimum 1 bit.
  - pwm_cnt: 8 bits.
  - duty_shadow: 8 bits.
- Prescaler:
  - tick = (pre_cnt == PRESCALE-1).
  - On tick, pre_cnt returns to 0; otherwise pre_cnt increments.
  - With PRESCALE = 1, tick is high every clock.
- PWM counter: on tick, pwm_cnt increments modulo 256 (255 → 0 wrap). It holds when there is no tick.
- Duty buffering: on the clock where tick is high and pwm_cnt == 255, duty_shadow loads pwm_duty_cycle. At no other time does duty_shadow change.
- PWM level, combinational from registered state:
  - pwm_level = 1 if duty_shadow == 0xFF.
  - Otherwise pwm_level = (pwm_cnt < duty_shadow), an unsigned 8-bit compare.
  - Resulting high time per period is duty_shadow ticks, or all 256 ticks when duty_shadow = 0xFF.
- Per-pin select, for i in 0..15 with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i] = 0 → out[i] <= 0, regardless of en_pwm[i].
  - en_out[i] = 1 and en_pwm[i] = 0 → out[i] <= 1 (static high).
  - en_out[i] = 1 and en_pwm[i] = 1 → out[i] <= pwm_level.
- period_start <= tick && (pwm_cnt == 255). It is a single-clock pulse coincident with pwm_cnt becoming 0.
- Enable and mode inputs are not buffered; they take effect on the next clock.

## Timing
- Reset values (asynchronous, with no clock required):
  - pre_cnt = 0, pwm_cnt = 0, duty_shadow = 0x00.
  - out = 16'h0000, period_start = 0.
- After reset release:
  - The first period runs with duty_shadow = 0, so PWM-mode pins are low for the first 256 × PRESCALE clocks.
  - The requested duty applies from the second period on.
- Latency:
  - out lags its enable/mode inputs and the pwm_cnt/duty_shadow state by exactly 1 clock.
  - The first PWM-high output of a period appears 1 clock after pwm_cnt wraps to 0.
- Period length is exactly 256 × PRESCALE clocks. period_start pulses are spaced by that amount.
- A pwm_duty_cycle change mid-period:
  - The current period finishes with the old duty.
  - The new value is sampled only at the wrap clock; the last value present on that clock wins.
  - Intermediate values that change and revert before the wrap are never seen.
- Simultaneous events:
  - An enable change on the wrap clock is applied on the next clock alongside the new duty.
  - rst asserted at any point clears everything immediately; counting restarts from 0 on the first clock after deassertion.
- Boundary duties:
  - 0x00 → constant 0.
  - 0x01 → high for 1 tick (PRESCALE clocks).
  - 0xFE → high for 254 ticks.
  - 0xFF → constant 1, with no one-tick low gap.

## Test plan
- **Reset mid-run:** run 1000 clocks with all pins enabled and in PWM mode, then pulse rst asynchronously → out = 0x0000 and period_start = 0 before the next clock edge; the first period_start appears 3328 clocks after release.
- **Static enables:** en_out = 0x00FF, en_pwm = 0x0000 → out = 0x00FF one clock later; then en_out = 0x0000 → out = 0x0000 one clock later.
- **50 % duty:** PRESCALE = 13, duty 0x80, en_out_7_0 = en_pwm_7_0 = 0x01 → from the second period, out[0] is high 1664 and low 1664 clocks per 3328-clock period.
- **Extremes:** duty 0x00 → out[0] never high; duty 0xFF → out[0] constantly high with no glitch at the wrap; both checked across 3 periods.
- **Buffering:** duty 0x40, change to 0xC0 at pwm_cnt = 100 → current period high time is 64 ticks (832 clocks); next period is 192 ticks (2496 clocks).
- **Mixed pins with PRESCALE = 1:**
  - Setup: en_out = 0xFFFF, en_pwm = 0xAAAA, duty 0x10.
  - Expected: even pins are constant high; odd pins are high for 16 of every 256 clocks.
  - Expected: period_start is spaced exactly 256 clocks apart.
